// File: rtl/mem_host_arb_if.sv
// Host-side req/gnt/rvalid buses plus the single SRAM port around mem_host_arb.
// Per-host fields are flattened, with host h occupying slice [h*W +: W].
interface mem_host_arb_if #(
    parameter int NumHosts  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [NumHosts-1:0]             host_req;
    logic [NumHosts-1:0]             host_gnt;
    logic [NumHosts-1:0]             host_we;
    logic [NumHosts*DataWidth/8-1:0] host_be;
    logic [NumHosts*AddrWidth-1:0]   host_addr;
    logic [NumHosts*DataWidth-1:0]   host_wdata;
    logic [NumHosts-1:0]             host_rvalid;
    logic [NumHosts-1:0]             host_err;
    logic [NumHosts*DataWidth-1:0]   host_rdata;
    logic                            mem_req;
    logic                            mem_we;
    logic [DataWidth/8-1:0]          mem_be;
    logic [AddrWidth-1:0]            mem_addr;
    logic [DataWidth-1:0]            mem_wdata;
    logic                            mem_rvalid;
    logic [DataWidth-1:0]            mem_rdata;

    modport slave (
        input  host_req, host_we, host_be, host_addr, host_wdata, mem_rvalid, mem_rdata,
        output host_gnt, host_rvalid, host_err, host_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output host_req, host_we, host_be, host_addr, host_wdata, mem_rvalid, mem_rdata,
        input  host_gnt, host_rvalid, host_err, host_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_host_arb.sv
// N-host to single-SRAM arbiter: same-cycle grant, one-cycle response, and a
// locally generated error response for addresses outside the SRAM window.
module mem_host_arb #(
    parameter int                   NumHosts   = 2,
    parameter int                   AddrWidth  = 32,
    parameter int                   DataWidth  = 32,
    parameter logic [AddrWidth-1:0] MemStart   = 32'h0000_0000,
    parameter logic [AddrWidth-1:0] MemMask    = 32'h0000_FFFF,
    parameter bit                   RoundRobin = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_host_arb_if.slave bus_io
);
    localparam int BeWidth  = DataWidth / 8;
    localparam int PtrWidth = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam logic [PtrWidth:0] HostCount = (PtrWidth + 1)'(NumHosts);

    logic [PtrWidth-1:0]  ptr_q, ptr_d;
    logic [PtrWidth-1:0]  resp_host_q, resp_host_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [PtrWidth-1:0]  winner;
    logic                 any_req;
    logic                 grant;
    logic                 in_window;
    logic [AddrWidth-1:0] win_addr;
    logic [DataWidth-1:0] resp_data;

    // Scan hosts starting at ptr_q and wrapping; the first requester wins.
    always_comb begin
        logic [PtrWidth:0] cand;
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < NumHosts; i++) begin
            cand = {1'b0, ptr_q} + (PtrWidth + 1)'(i);
            if (cand >= HostCount) begin
                cand = cand - HostCount;
            end
            if (!any_req && bus_io.host_req[cand[PtrWidth-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[PtrWidth-1:0];
            end
        end
    end

    assign grant     = rst_ni & any_req;
    assign win_addr  = bus_io.host_addr[int'(winner)*AddrWidth +: AddrWidth];
    assign in_window = (win_addr & ~MemMask) == MemStart;

    always_comb begin
        bus_io.host_gnt  = '0;
        bus_io.mem_req   = 1'b0;
        bus_io.mem_we    = 1'b0;
        bus_io.mem_be    = '0;
        bus_io.mem_addr  = '0;
        bus_io.mem_wdata = '0;
        if (grant) begin
            bus_io.host_gnt[winner] = 1'b1;
            bus_io.mem_req          = in_window;
            bus_io.mem_we           = bus_io.host_we[winner];
            bus_io.mem_be           = bus_io.host_be[int'(winner)*BeWidth +: BeWidth];
            bus_io.mem_addr         = win_addr;
            bus_io.mem_wdata        = bus_io.host_wdata[int'(winner)*DataWidth +: DataWidth];
        end
    end

    always_comb begin
        logic [PtrWidth:0] nxt;
        nxt = {1'b0, winner} + (PtrWidth + 1)'(1);
        if (nxt >= HostCount) begin
            nxt = '0;
        end
        ptr_d = ptr_q;
        if (grant && RoundRobin) begin
            ptr_d = nxt[PtrWidth-1:0];
        end
        resp_valid_d = grant;
        resp_err_d   = grant & ~in_window;
        resp_host_d  = grant ? winner : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_host_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_host_q  <= resp_host_d;
        end
    end

    // Read data is shared by all hosts; only the rvalid/err bits are steered.
    assign resp_data = (resp_valid_q && !resp_err_q) ? bus_io.mem_rdata : '0;

    always_comb begin
        bus_io.host_rvalid = '0;
        bus_io.host_err    = '0;
        if (resp_valid_q) begin
            bus_io.host_rvalid[resp_host_q] = 1'b1;
            bus_io.host_err[resp_host_q]    = resp_err_q;
        end
        bus_io.host_rdata = {NumHosts{resp_data}};
    end

    mem_rvalid_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_io.mem_rvalid == (resp_valid_q & ~resp_err_q));

endmodule

// File: tb/tb_mem_host_arb.sv
// Drives a round-robin and a fixed-priority mem_host_arb with directed and random
// host traffic, comparing every cycle against a transaction-level reference model.
module tb_mem_host_arb;
    localparam int NH       = 2;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;
    localparam int NDUT     = 2;
    localparam int RR_DUT   = 0;
    localparam int MemWords = 16;
    localparam logic [AW-1:0] MEM_START  = 32'h0000_0000;
    localparam logic [AW-1:0] MEM_MASK   = 32'h0000_FFFF;
    localparam logic [DW-1:0] IDLE_RDATA = 32'hBADC_0FFE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NH-1:0]    t_req   [NDUT];
    logic [NH-1:0]    t_we    [NDUT];
    logic [BW-1:0]    t_be    [NDUT][NH];
    logic [AW-1:0]    t_addr  [NDUT][NH];
    logic [DW-1:0]    t_wdata [NDUT][NH];

    logic [NH-1:0]    o_gnt    [NDUT];
    logic [NH-1:0]    o_rvalid [NDUT];
    logic [NH-1:0]    o_err    [NDUT];
    logic [NH*DW-1:0] o_rdata  [NDUT];
    logic             o_mreq   [NDUT];
    logic             o_mwe    [NDUT];
    logic [BW-1:0]    o_mbe    [NDUT];
    logic [AW-1:0]    o_maddr  [NDUT];
    logic [DW-1:0]    o_mwdata [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_host_arb_if #(.NumHosts(NH), .AddrWidth(AW), .DataWidth(DW)) bus ();
        logic [DW-1:0] st_mem [MemWords];

        mem_host_arb #(
            .NumHosts  (NH),
            .AddrWidth (AW),
            .DataWidth (DW),
            .MemStart  (MEM_START),
            .MemMask   (MEM_MASK),
            .RoundRobin(g == RR_DUT)
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus_io(bus)
        );

        assign bus.host_req = t_req[g];
        assign bus.host_we  = t_we[g];
        for (genvar h = 0; h < NH; h++) begin : g_host
            assign bus.host_be[h*BW +: BW]    = t_be[g][h];
            assign bus.host_addr[h*AW +: AW]  = t_addr[g][h];
            assign bus.host_wdata[h*DW +: DW] = t_wdata[g][h];
        end

        assign o_gnt[g]    = bus.host_gnt;
        assign o_rvalid[g] = bus.host_rvalid;
        assign o_err[g]    = bus.host_err;
        assign o_rdata[g]  = bus.host_rdata;
        assign o_mreq[g]   = bus.mem_req;
        assign o_mwe[g]    = bus.mem_we;
        assign o_mbe[g]    = bus.mem_be;
        assign o_maddr[g]  = bus.mem_addr;
        assign o_mwdata[g] = bus.mem_wdata;

        // Single-port SRAM stub: answers exactly one cycle after each request.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bus.mem_rvalid <= 1'b0;
                bus.mem_rdata  <= '0;
                for (int i = 0; i < MemWords; i++) st_mem[i] <= '0;
            end else begin
                bus.mem_rvalid <= bus.mem_req;
                bus.mem_rdata  <= IDLE_RDATA;
                if (bus.mem_req) begin
                    if (bus.mem_we) begin
                        bus.mem_rdata <= '0;
                        for (int b = 0; b < BW; b++)
                            if (bus.mem_be[b])
                                st_mem[bus.mem_addr[5:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
                    end else begin
                        bus.mem_rdata <= st_mem[bus.mem_addr[5:2]];
                    end
                end
            end
        end
    end

    int            m_ptr   [NDUT];
    bit            p_valid [NDUT];
    bit            p_err   [NDUT];
    int            p_host  [NDUT];
    logic [DW-1:0] p_rdata [NDUT];
    logic [DW-1:0] m_mem   [NDUT][MemWords];
    logic [NH-1:0] g_last  [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NH-1:0] onehot(input int i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic string tag(input int d, input string s);
        return $sformatf("dut%0d_%s", d, s);
    endfunction

    task automatic drive(input int h, input bit req, input bit we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        for (int d = 0; d < NDUT; d++) begin
            t_req[d][h]   = req;
            t_we[d][h]    = we;
            t_be[d][h]    = be;
            t_addr[d][h]  = addr;
            t_wdata[d][h] = wdata;
        end
    endtask

    task automatic idle();
        for (int h = 0; h < NH; h++) drive(h, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_host(input int d, input int h);
        t_req[d][h]   = ($urandom_range(0, 3) != 0);
        t_we[d][h]    = 1'($urandom_range(0, 1));
        t_be[d][h]    = BW'($urandom_range(1, (1 << BW) - 1));
        t_wdata[d][h] = $urandom;
        if ($urandom_range(0, 7) == 0) t_addr[d][h] = 32'h0001_0000 | ($urandom & 32'hFFFE_FFFC);
        else                           t_addr[d][h] = $urandom & 32'h0000_FFFC;
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_ptr[d]   = 0;
            p_valid[d] = 1'b0;
            p_err[d]   = 1'b0;
            p_host[d]  = 0;
            p_rdata[d] = '0;
            g_last[d]  = '0;
            for (int i = 0; i < MemWords; i++) m_mem[d][i] = '0;
        end
    endtask

    // One clock: check this cycle's grant/SRAM port and last cycle's response, then advance the model.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            bit               any;
            bit               inwin;
            int               w;
            int               idx;
            logic [DW-1:0]    rd;
            logic [NH*DW-1:0] er;
            any = 1'b0;
            w   = 0;
            for (int k = 0; k < NH; k++) begin
                int h;
                h = (m_ptr[d] + k) % NH;
                if (!any && t_req[d][h]) begin
                    any = 1'b1;
                    w   = h;
                end
            end
            inwin = any && ((t_addr[d][w] & ~MEM_MASK) == MEM_START);

            chk(tag(d, "gnt"),       64'(o_gnt[d]),    64'(any ? onehot(w) : '0));
            chk(tag(d, "mem_req"),   64'(o_mreq[d]),   64'(inwin));
            chk(tag(d, "mem_we"),    64'(o_mwe[d]),    64'(any ? t_we[d][w] : 1'b0));
            chk(tag(d, "mem_be"),    64'(o_mbe[d]),    64'(any ? t_be[d][w] : '0));
            chk(tag(d, "mem_addr"),  64'(o_maddr[d]),  64'(any ? t_addr[d][w] : '0));
            chk(tag(d, "mem_wdata"), 64'(o_mwdata[d]), 64'(any ? t_wdata[d][w] : '0));
            chk(tag(d, "rvalid"),    64'(o_rvalid[d]), 64'(p_valid[d] ? onehot(p_host[d]) : '0));
            chk(tag(d, "err"),       64'(o_err[d]),
                64'((p_valid[d] && p_err[d]) ? onehot(p_host[d]) : '0));
            if (p_valid[d]) begin
                er = '0;
                for (int h = 0; h < NH; h++) er[h*DW +: DW] = p_err[d] ? '0 : p_rdata[d];
                chk(tag(d, "rdata"), 64'(o_rdata[d]), 64'(er));
            end

            rd = '0;
            if (inwin) begin
                idx = int'(t_addr[d][w][5:2]);
                if (t_we[d][w]) begin
                    for (int b = 0; b < BW; b++)
                        if (t_be[d][w][b]) m_mem[d][idx][b*8 +: 8] = t_wdata[d][w][b*8 +: 8];
                end else begin
                    rd = m_mem[d][idx];
                end
            end
            p_valid[d] = any;
            p_err[d]   = any && !inwin;
            p_host[d]  = w;
            p_rdata[d] = rd;
            if (any && d == RR_DUT) m_ptr[d] = (w + 1) % NH;
            g_last[d] = any ? onehot(w) : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int h = 0; h < NH; h++) drive(h, 1'b1, 1'b0, '1, 32'h100, '0);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk(tag(d, "rst_gnt"),      64'(o_gnt[d]),    64'(0));
            chk(tag(d, "rst_mem_req"),  64'(o_mreq[d]),   64'(0));
            chk(tag(d, "rst_mem_addr"), 64'(o_maddr[d]),  64'(0));
            chk(tag(d, "rst_rvalid"),   64'(o_rvalid[d]), 64'(0));
            chk(tag(d, "rst_err"),      64'(o_err[d]),    64'(0));
            chk(tag(d, "rst_rdata"),    64'(o_rdata[d]),  64'(0));
        end
        model_reset();
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        do_reset();

        // Single read from host0
        drive(0, 1'b1, 1'b0, '1, 32'h100, '0);
        #1;
        chk("t1_gnt", 64'(o_gnt[0]), 64'(2'b01));
        chk("t1_mem_req", 64'(o_mreq[0]), 64'(1));
        chk("t1_mem_addr", 64'(o_maddr[0]), 64'(32'h100));
        step();
        idle();
        #1;
        chk("t1_rvalid", 64'(o_rvalid[0]), 64'(2'b01));
        chk("t1_err", 64'(o_err[0]), 64'(2'b00));
        step();

        // Round-robin alternation with both hosts requesting continuously
        do_reset();
        drive(0, 1'b1, 1'b0, '1, 32'h40, '0);
        drive(1, 1'b1, 1'b0, '1, 32'h44, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_gnt", 64'(o_gnt[RR_DUT]), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k > 0) chk("t2_rvalid", 64'(o_rvalid[RR_DUT]), 64'((k % 2 == 1) ? 2'b01 : 2'b10));
            step();
        end
        idle();
        #1;
        chk("t2_rvalid_last", 64'(o_rvalid[RR_DUT]), 64'(2'b10));
        step();

        // Fixed priority: host0 starves host1 until it drops its request
        drive(0, 1'b1, 1'b0, '1, 32'h48, '0);
        drive(1, 1'b1, 1'b0, '1, 32'h4C, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_gnt", 64'(o_gnt[1 - RR_DUT]), 64'(2'b01));
            step();
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("t3_gnt_host1", 64'(o_gnt[1 - RR_DUT]), 64'(2'b10));
        step();
        idle();
        step();

        // Out-of-window read gets an error response without touching SRAM
        drive(1, 1'b1, 1'b0, '1, 32'h0001_0000, '0);
        #1;
        chk("t4_gnt", 64'(o_gnt[0]), 64'(2'b10));
        chk("t4_mem_req", 64'(o_mreq[0]), 64'(0));
        step();
        idle();
        #1;
        chk("t4_rvalid", 64'(o_rvalid[0]), 64'(2'b10));
        chk("t4_err", 64'(o_err[0]), 64'(2'b10));
        chk("t4_rdata", 64'(o_rdata[0]), 64'(0));
        step();

        // Partial write, then read it back
        drive(0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        #1;
        chk("t5_mem_we", 64'(o_mwe[0]), 64'(1));
        chk("t5_mem_be", 64'(o_mbe[0]), 64'(4'b0011));
        chk("t5_mem_wdata", 64'(o_mwdata[0]), 64'(32'hDEAD_BEEF));
        step();
        drive(0, 1'b1, 1'b0, '1, 32'h20, '0);
        #1;
        chk("t5_rvalid", 64'(o_rvalid[0]), 64'(2'b01));
        chk("t5_err", 64'(o_err[0]), 64'(2'b00));
        step();
        idle();
        #1;
        chk("t5_rdata", 64'(o_rdata[0][31:0]), 64'(32'h0000_BEEF));
        step();

        // Reset with a response pending, after granting host1 and then host0
        drive(1, 1'b1, 1'b0, '1, 32'h80, '0);
        step();
        do_reset();
        drive(0, 1'b1, 1'b0, '1, 32'h84, '0);
        drive(1, 1'b1, 1'b0, '1, 32'h88, '0);
        #1;
        chk("t6_gnt", 64'(o_gnt[RR_DUT]), 64'(2'b01));
        step();
        idle();
        drive(0, 1'b1, 1'b0, '1, 32'h8C, '0);
        step();
        do_reset();
        drive(0, 1'b1, 1'b0, '1, 32'h84, '0);
        drive(1, 1'b1, 1'b0, '1, 32'h88, '0);
        #1;
        chk("t6b_gnt", 64'(o_gnt[RR_DUT]), 64'(2'b01));
        step();
        idle();
        step();

        // Random traffic; a host keeps its request stable until it is granted
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < NDUT; d++)
                for (int h = 0; h < NH; h++)
                    if (!t_req[d][h] || g_last[d][h]) rand_host(d, h);
            step();
        end
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
